// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
// uart_rx_fifo
// Receive-side byte buffer behind a UART receiver. A rising edge on rx_done
// captures one byte into a circular FIFO. The host reads the head through a
// first-word-fall-through valid/ready port. The block also reports fill
// level, a sticky overflow flag and a saturating count of dropped bytes.
module uart_rx_fifo #(
   parameter int DEPTH     = 16,
   parameter int AW        = 4,
   parameter int AF_THRESH = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    rx_data,
   input  logic          rx_done,
   output logic [7:0]    rd_data,
   output logic          rd_valid,
   input  logic          rd_ready,
   output logic [AW:0]   level,
   output logic          empty,
   output logic          full,
   output logic          almost_full,
   output logic          overflow,
   input  logic          clr_overflow,
   output logic [7:0]    drop_cnt
);

   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
   localparam logic [AW:0] AF_L    = (AW+1)'(AF_THRESH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          rx_done_d;
   logic          push;
   logic          pop;
   logic          accept;
   logic          drop;

   // Status flags and the head-of-queue view, all straight from level/rd_ptr
   always_comb begin
      empty       = (level == '0);
      full        = (level == DEPTH_L);
      almost_full = (level >= AF_L);
      rd_valid    = ~empty;
      rd_data     = mem[rd_ptr];
   end

   // Transfer qualifiers: one push per rx_done rising edge; a push into a full
   // FIFO only succeeds when the head is being consumed in the same cycle
   always_comb begin
      push   = rx_done & ~rx_done_d;
      pop    = rd_valid & rd_ready;
      accept = push & (~full | pop);
      drop   = push & full & ~pop;
   end

   // Storage array; contents are not reset, only the pointers are
   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wr_ptr] <= rx_data;
      end
   end

   // Edge-detect register, pointers and the up/down level counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_done_d <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
      end else begin
         rx_done_d <= rx_done;
         if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (accept && !pop) begin
            level <= level + 1'b1;
         end else if (pop && !accept) begin
            level <= level - 1'b1;
         end
      end
   end

   // Sticky overflow and saturating drop counter; a drop beats a clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (clr_overflow) begin
            drop_cnt <= 8'd1;
         end else if (drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 1'b1;
         end
      end else if (clr_overflow) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
// Testbench for uart_rx_fifo: queue-based reference model updated on each
// clock edge, a compare process on every falling edge, directed scenarios
// with literal expectations, and randomized traffic.
module tb_uart_rx_fifo;

   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int AF    = 12;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    rx_data;
   logic          rx_done;
   logic [7:0]    rd_data;
   logic          rd_valid;
   logic          rd_ready;
   logic [AW:0]   level;
   logic          empty;
   logic          full;
   logic          almost_full;
   logic          overflow;
   logic          clr_overflow;
   logic [7:0]    drop_cnt;

   int tests  = 0;
   int failed = 0;

   uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW), .AF_THRESH(AF)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .level(level), .empty(empty), .full(full), .almost_full(almost_full),
      .overflow(overflow), .clr_overflow(clr_overflow), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         failed++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0] mq[$];
   logic       m_prev = 1'b0;
   logic       m_ovf  = 1'b0;
   int         m_cnt  = 0;
   logic [7:0] last_out = 8'h00;

   always @(posedge clk or posedge rst) begin
      bit m_push, m_pop, m_full, m_drop;
      if (rst) begin
         mq.delete();
         m_prev = 1'b0;
         m_ovf  = 1'b0;
         m_cnt  = 0;
      end else begin
         m_push = rx_done && !m_prev;
         m_prev = rx_done;
         m_pop  = (mq.size() > 0) && rd_ready;
         m_full = (mq.size() == DEPTH);
         m_drop = m_push && m_full && !m_pop;
         if (m_pop) last_out = mq.pop_front();
         if (m_push && !m_drop) mq.push_back(rx_data);
         if (m_drop) begin
            m_ovf = 1'b1;
            m_cnt = clr_overflow ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
         end else if (clr_overflow) begin
            m_ovf = 1'b0;
            m_cnt = 0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      chk("rd_valid", int'(rd_valid), int'(mq.size() > 0));
      if (mq.size() > 0) chk("rd_data", int'(rd_data), int'(mq[0]));
      chk("level", int'(level), mq.size());
      chk("empty", int'(empty), int'(mq.size() == 0));
      chk("full", int'(full), int'(mq.size() == DEPTH));
      chk("almost_full", int'(almost_full), int'(mq.size() >= AF));
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("drop_cnt", int'(drop_cnt), m_cnt);
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input int hold);
      rx_data = b;
      rx_done = 1'b1;
      repeat (hold) cyc();
      rx_done = 1'b0;
      cyc();
   endtask

   task automatic drain();
      int n = 0;
      rd_ready = 1'b1;
      while (mq.size() > 0 && n < 100) begin
         cyc();
         n++;
      end
      rd_ready = 1'b0;
      chk("drain_bound", int'(mq.size() == 0), 1);
   endtask

   task automatic fill_to(input int target);
      int n = 0;
      while (mq.size() < target && n < 100) begin
         send_byte(8'($urandom), 1);
         n++;
      end
      chk("fill_bound", mq.size(), target);
   endtask

   initial begin
      int pushed;
      int iter;
      rst = 1'b1; rx_data = 8'h00; rx_done = 1'b0; rd_ready = 1'b0; clr_overflow = 1'b0;
      repeat (2) cyc();
      chk("rst_empty", int'(empty), 1);
      chk("rst_valid", int'(rd_valid), 0);
      chk("rst_level", int'(level), 0);
      rst = 1'b0;
      cyc();

      // single byte with long rx_done
      rx_data = 8'hA5; rx_done = 1'b1;
      cyc();
      chk("single_valid", int'(rd_valid), 1);
      chk("single_data", int'(rd_data), 8'hA5);
      chk("single_level", int'(level), 1);
      repeat (4) cyc();
      chk("single_once", int'(level), 1);
      rx_done = 1'b0; rd_ready = 1'b1;
      cyc();
      rd_ready = 1'b0;
      chk("single_pop_empty", int'(empty), 1);
      chk("single_pop_level", int'(level), 0);

      // fill 0x00..0x0F
      for (int i = 0; i < 16; i++) begin
         send_byte(8'(i), 1);
         if (i == 10) chk("af_below", int'(almost_full), 0);
         if (i == 11) chk("af_at12", int'(almost_full), 1);
      end
      chk("fill_full", int'(full), 1);
      chk("fill_level", int'(level), 16);

      // overflow
      send_byte(8'h55, 1);
      send_byte(8'h66, 1);
      chk("ovf_flag", int'(overflow), 1);
      chk("ovf_cnt", int'(drop_cnt), 2);
      chk("ovf_level", int'(level), 16);
      chk("ovf_head", int'(rd_data), 8'h00);
      clr_overflow = 1'b1; cyc(); clr_overflow = 1'b0;
      chk("clr_flag", int'(overflow), 0);
      chk("clr_cnt", int'(drop_cnt), 0);

      // push while full with simultaneous pop
      rx_data = 8'h77; rx_done = 1'b1; rd_ready = 1'b1;
      cyc();
      rx_done = 1'b0; rd_ready = 1'b0;
      cyc();
      chk("pp_ovf", int'(overflow), 0);
      chk("pp_level", int'(level), 16);
      rd_ready = 1'b1;
      for (int k = 1; k < 17; k++) begin
         chk("pp_order", int'(rd_data), (k == 16) ? 8'h77 : k);
         cyc();
      end
      rd_ready = 1'b0;
      chk("pp_last", int'(last_out), 8'h77);
      chk("pp_empty", int'(empty), 1);

      // streaming with level kept within 0..5
      pushed = 0; iter = 0;
      while (pushed < 40 && iter < 1000) begin
         if (mq.size() < 5 && $urandom_range(0, 3) != 0) begin
            rx_data = 8'($urandom); rx_done = 1'b1; pushed++;
         end
         rd_ready = 1'($urandom);
         cyc();
         rx_done = 1'b0; rd_ready = 1'($urandom);
         cyc();
         iter++;
      end
      chk("stream_bound", pushed, 40);
      drain();

      // free-running random traffic including overflow and clears
      for (int c = 0; c < 600; c++) begin
         rx_data = 8'($urandom);
         rx_done = ($urandom_range(0, 2) != 0);
         rd_ready = ($urandom_range(0, 3) == 0);
         clr_overflow = ($urandom_range(0, 40) == 0);
         cyc();
      end
      rx_done = 1'b0; rd_ready = 1'b0; clr_overflow = 1'b0;
      cyc();

      // drop counter saturation
      drain();
      clr_overflow = 1'b1; cyc(); clr_overflow = 1'b0;
      fill_to(DEPTH);
      for (int d = 0; d < 260; d++) send_byte(8'hEE, 1);
      chk("sat_cnt", int'(drop_cnt), 255);
      chk("sat_level", int'(level), 16);

      // clear and drop in the same cycle: drop wins
      clr_overflow = 1'b1; cyc(); clr_overflow = 1'b0;
      chk("clr2_cnt", int'(drop_cnt), 0);
      rx_data = 8'h99; rx_done = 1'b1; clr_overflow = 1'b1;
      cyc();
      rx_done = 1'b0; clr_overflow = 1'b0;
      chk("clrdrop_flag", int'(overflow), 1);
      chk("clrdrop_cnt", int'(drop_cnt), 1);
      cyc();

      // async reset mid-stream
      drain();
      fill_to(7);
      chk("pre_rst_level", int'(level), 7);
      #2 rst = 1'b1;
      #1;
      chk("arst_empty", int'(empty), 1);
      chk("arst_level", int'(level), 0);
      chk("arst_valid", int'(rd_valid), 0);
      rx_data = 8'h3C; rx_done = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      repeat (4) cyc();
      chk("arst_one_push", int'(level), 1);
      chk("arst_data", int'(rd_data), 8'h3C);
      rx_done = 1'b0;
      cyc();
      drain();
      cyc();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer placed directly downstream of the UART receiver. It captures each completed byte, using a rising-edge detect on the receiver's done strobe, and stores it in a circular FIFO. The buffered bytes are presented to the host/bus side through a first-word-fall-through valid/ready interface. It also provides fill-level status, a sticky overflow flag and a saturating count of dropped bytes.

Parameters:
DEPTH, 16, number of byte entries; must be a power of 2 and at least 2
AW, 4, pointer width; equals log2(DEPTH)
AF_THRESH, 12, almost_full asserts when level >= AF_THRESH; legal range 1..DEPTH

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
rx_data  input  8  received byte from UART receiver; stable while rx_done is high
rx_done  input  1  receiver done flag; may stay high for several clk cycles per byte
rd_data  output  8  byte at FIFO head; valid only while rd_valid=1
rd_valid  output  1  FIFO non-empty
rd_ready  input  1  consumer accepts rd_data this cycle
level  output  AW+1  number of stored bytes, 0..DEPTH
empty  output  1  level==0
full  output  1  level==DEPTH
almost_full  output  1  level>=AF_THRESH
overflow  output  1  sticky flag: a byte was dropped
clr_overflow  input  1  clears overflow and drop_cnt
drop_cnt  output  8  saturating count of dropped bytes

Behaviour:
- Reset values (async, rst=1): wr_ptr=0, rd_ptr=0, level=0, rx_done_d=0, overflow=0, drop_cnt=0. Resulting outputs: empty=1, full=0, almost_full=0, rd_valid=0. Memory contents are don't-care.
- Edge detect: rx_done_d is a registered copy of rx_done. push = rx_done & ~rx_done_d. A single byte is written per rising edge, however long rx_done stays high. A new byte requires rx_done to return low for at least one clk.
- Push accept rule: accepted when level<DEPTH, or when level==DEPTH and a pop occurs in the same cycle. On accept, mem[wr_ptr]<=rx_data and wr_ptr increments.
- Push drop rule: when full with no simultaneous pop, the byte is discarded. overflow<=1 and drop_cnt increments, saturating at 255. mem, wr_ptr and level are unchanged.
- Pop: pop = rd_valid & rd_ready, and rd_ptr increments. rd_ready while empty has no effect.
- Read path is first-word-fall-through. rd_data = mem[rd_ptr] (combinational read). rd_valid = ~empty.
- Latency: if rx_done is first sampled high at edge N, rd_valid=1 and rd_data equals that byte after edge N, provided the FIFO was empty.
- Pointers wrap modulo DEPTH. level is a separate up/down counter:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
- level never exceeds DEPTH and never underflows.
- Simultaneous push and pop when empty: the pop cannot occur because rd_valid=0. The push is stored and level becomes 1.
- Status flags empty, full and almost_full are derived combinationally from level.
- clr_overflow: at the next edge, overflow<=0 and drop_cnt<=0. If a drop occurs in the same cycle, the drop wins: overflow=1 and drop_cnt=1.
- Reset mid-operation: all contents are discarded immediately (asynchronous). A rx_done held high through reset release produces one push, because rx_done_d=0.
- Ordering: bytes are read out in exactly the order they were pushed, and no byte is duplicated.

Test Plan:
- Single byte: rx_data=0xA5, rx_done high for 5 cycles -> exactly one push; rd_valid=1 the cycle after the first high sample; rd_data=0xA5; level=1. Pop with rd_ready=1 -> empty=1, level=0.
- Fill and order: push 0x00..0x0F with rd_ready=0 -> full=1, level=16. almost_full rises when level reaches 12. Drain -> bytes 0x00..0x0F read in order, then empty=1.
- Overflow: when full, push 0x55 and 0x66 -> overflow=1, drop_cnt=2, level=16, and head still 0x00. Pulse clr_overflow -> overflow=0, drop_cnt=0.
- Full with simultaneous push/pop: when full, push 0x77 in the same cycle as a pop -> overflow stays 0, level stays 16. The last byte read out is 0x77.
- Wrap-around: push/pop 40 bytes in a streaming pattern with level varying 0..5 -> all bytes in order and pointers wrap cleanly. Clear, then simultaneous clr_overflow and a drop -> overflow=1, drop_cnt=1.
- Async reset mid-stream: with level=7, assert rst between clock edges -> empty=1, level=0 and rd_valid=0 immediately. rx_done held high across release -> exactly one push.
